// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared widths, reset vector and PC-source select bit indices
//                for the fetch-stage program-counter logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned ADDR_WIDTH = 14;
  localparam int unsigned SEL_WIDTH  = 4;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [SEL_WIDTH-1:0]  sel_t;

  localparam addr_t RESET_VECTOR = 14'h0000;

  // Bit positions inside the one-hot PC-source select from the hazard unit
  localparam int unsigned SEL_BRANCH  = 0;
  localparam int unsigned SEL_INT     = 1;
  localparam int unsigned SEL_RET     = 2;
  localparam int unsigned SEL_RESTART = 3;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/pc_src_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_src_mux
//  Description : Combinational priority mux choosing the PC load value from
//                restart vector, interrupt, return, branch or sequential PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_src_mux
  import fetch_pkg::*;
(
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic [ADDR_WIDTH-1:0] int_addr_i,
  input  logic [ADDR_WIDTH-1:0] ret_addr_i,
  input  logic [ADDR_WIDTH-1:0] seq_addr_i,
  output logic [ADDR_WIDTH-1:0] load_addr_o
);

  // Priority restart > interrupt > return > branch > sequential; codes that
  // are not one-hot simply resolve to the highest-priority set bit.
  always_comb begin
    load_addr_o = seq_addr_i;
    if (sel_i[SEL_RESTART]) begin
      load_addr_o = RESET_VECTOR;
    end else if (sel_i[SEL_INT]) begin
      load_addr_o = int_addr_i;
    end else if (sel_i[SEL_RET]) begin
      load_addr_o = ret_addr_i;
    end else if (sel_i[SEL_BRANCH]) begin
      load_addr_o = branch_addr_i;
    end
  end

endmodule : pc_src_mux
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Fetch-stage program counter. Holds the PC, drives the
//                program-memory fetch address and PC+1 return address, and
//                loads the next PC from the selected source unless stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
  import fetch_pkg::*;
(
  input  logic                  clock,
  input  logic                  nreset,   // active-high, synchronous
  input  logic                  stall,
  input  logic [SEL_WIDTH-1:0]  prog_cntr_input_sel,
  input  logic [ADDR_WIDTH-1:0] branch_target_address,
  input  logic [ADDR_WIDTH-1:0] interrupt_branch_addr,
  input  logic [ADDR_WIDTH-1:0] ret_addr_mem,
  output logic [ADDR_WIDTH-1:0] prog_mem_fetch_read_addr,
  output logic [ADDR_WIDTH-1:0] ret_addr_out
);

  addr_t pc_q;
  addr_t pc_d;
  addr_t next_pc;
  addr_t load_addr;

  // Sequential successor wraps naturally at 2^ADDR_WIDTH
  assign next_pc = pc_q + addr_t'(1);

  pc_src_mux u_pc_src_mux (
    .sel_i         (prog_cntr_input_sel),
    .branch_addr_i (branch_target_address),
    .int_addr_i    (interrupt_branch_addr),
    .ret_addr_i    (ret_addr_mem),
    .seq_addr_i    (next_pc),
    .load_addr_o   (load_addr)
  );

  // Stall holds the PC; a redirect seen during a stall is dropped, the hazard
  // unit re-presents it on the first non-stalled cycle.
  always_comb begin
    pc_d = load_addr;
    if (stall) begin
      pc_d = pc_q;
    end
  end

  // PC register; reset overrides stall and every select
  always_ff @(posedge clock) begin
    if (nreset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign prog_mem_fetch_read_addr = pc_q;
  assign ret_addr_out             = next_pc;

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Directed self-checking bench for fetch_pc_unit using an
//                expected-PC scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  logic        clock = 1'b0;
  logic        nreset;
  logic        stall;
  logic [3:0]  sel;
  logic [13:0] br_addr;
  logic [13:0] int_addr;
  logic [13:0] ret_mem;
  logic [13:0] fetch_addr;
  logic [13:0] ret_out;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  logic [13:0] model_pc = 14'h0000;

  always #5 clock = ~clock;

  fetch_pc_unit dut (
    .clock                    (clock),
    .nreset                   (nreset),
    .stall                    (stall),
    .prog_cntr_input_sel      (sel),
    .branch_target_address    (br_addr),
    .interrupt_branch_addr    (int_addr),
    .ret_addr_mem             (ret_mem),
    .prog_mem_fetch_read_addr (fetch_addr),
    .ret_addr_out             (ret_out)
  );

  // Reference next-PC from the input set, independent of the design
  function automatic logic [13:0] ref_next(input logic rst, input logic stl,
                                           input logic [3:0] s,
                                           input logic [13:0] pc,
                                           input logic [13:0] b,
                                           input logic [13:0] i,
                                           input logic [13:0] r);
    logic [13:0] one;
    one = 14'h0001;
    if (rst)       return 14'h0000;
    if (stl)       return pc;
    if (s[3])      return 14'h0000;
    if (s[1])      return i;
    if (s[2])      return r;
    if (s[0])      return b;
    return pc + one;
  endfunction

  // One clock: drive inputs, push expectation, clock, pop and compare
  task automatic step(input string tag, input logic rst, input logic stl,
                      input logic [3:0] s, input logic [13:0] b,
                      input logic [13:0] i, input logic [13:0] r);
    logic [13:0] exp_pc;
    logic [13:0] exp_ret;
    nreset   = rst;
    stall    = stl;
    sel      = s;
    br_addr  = b;
    int_addr = i;
    ret_mem  = r;
    exp_q.push_back(ref_next(rst, stl, s, model_pc, b, i, r));
    @(posedge clock);
    #1;
    exp_pc   = exp_q.pop_front();
    exp_ret  = exp_pc + 14'h0001;
    model_pc = exp_pc;
    checks++;
    assert (fetch_addr === exp_pc) else begin
      errors++;
      $error("FAIL %s fetch_addr observed %h expected %h", tag, fetch_addr, exp_pc);
    end
    checks++;
    assert (ret_out === exp_ret) else begin
      errors++;
      $error("FAIL %s ret_addr_out observed %h expected %h", tag, ret_out, exp_ret);
    end
  endtask

  initial begin
    nreset = 1'b1; stall = 1'b0; sel = 4'h0;
    br_addr = '0; int_addr = '0; ret_mem = '0;
    @(negedge clock);

    step("reset0", 1'b1, 1'b0, 4'h0, 14'h0000, 14'h0000, 14'h0000);
    step("reset1", 1'b1, 1'b1, 4'h2, 14'h0111, 14'h0222, 14'h0333);

    // Sequential fetch 1..5
    for (int k = 0; k < 5; k++)
      step("seq", 1'b0, 1'b0, 4'h0, 14'h0000, 14'h0000, 14'h0000);

    // Branch, then sequential past it
    step("branch",   1'b0, 1'b0, 4'b0001, 14'h0123, 14'h0000, 14'h0000);
    step("post_br",  1'b0, 1'b0, 4'b0000, 14'h0000, 14'h0000, 14'h0000);

    // Interrupt wins over branch; return-address load
    step("int_pri",  1'b0, 1'b0, 4'b0011, 14'h0200, 14'h0010, 14'h0000);
    step("ret_load", 1'b0, 1'b0, 4'b0100, 14'h0000, 14'h0000, 14'h0124);
    step("int_ret",  1'b0, 1'b0, 4'b0110, 14'h0000, 14'h0ABC, 14'h0DEF);
    step("ret_br",   1'b0, 1'b0, 4'b0101, 14'h0777, 14'h0000, 14'h0555);

    // Stall at 0x0040 for three cycles, then release
    step("to_40",    1'b0, 1'b0, 4'b0001, 14'h0040, 14'h0000, 14'h0000);
    for (int k = 0; k < 3; k++)
      step("stall",  1'b0, 1'b1, 4'b0000, 14'h0000, 14'h0000, 14'h0000);
    step("unstall",  1'b0, 1'b0, 4'b0000, 14'h0000, 14'h0000, 14'h0000);

    // Redirect held through a stall is captured only once stall drops
    step("stall_br", 1'b0, 1'b1, 4'b0001, 14'h0300, 14'h0000, 14'h0000);
    step("stall_br", 1'b0, 1'b1, 4'b0001, 14'h0300, 14'h0000, 14'h0000);
    step("rel_br",   1'b0, 1'b0, 4'b0001, 14'h0300, 14'h0000, 14'h0000);

    // Wrap-around at the top of the address space
    step("to_3fff",  1'b0, 1'b0, 4'b0001, 14'h3FFF, 14'h0000, 14'h0000);
    step("wrap",     1'b0, 1'b0, 4'b0000, 14'h0000, 14'h0000, 14'h0000);
    step("post_wrap",1'b0, 1'b0, 4'b0000, 14'h0000, 14'h0000, 14'h0000);

    // Reset in the middle of an interrupt redirect discards it
    step("pre_rst",  1'b0, 1'b0, 4'b0001, 14'h1234, 14'h0000, 14'h0000);
    step("rst_int",  1'b1, 1'b0, 4'b0010, 14'h0000, 14'h0155, 14'h0000);
    step("after_rst",1'b0, 1'b0, 4'b0000, 14'h0000, 14'h0000, 14'h0000);

    // Forced restart, alone and with every select bit set
    step("pre_rs",   1'b0, 1'b0, 4'b0001, 14'h2A2A, 14'h0000, 14'h0000);
    step("restart",  1'b0, 1'b0, 4'b1000, 14'h0000, 14'h0000, 14'h0000);
    step("pre_rs2",  1'b0, 1'b0, 4'b0001, 14'h1555, 14'h0000, 14'h0000);
    step("restart_all", 1'b0, 1'b0, 4'b1111, 14'h0101, 14'h0202, 14'h0303);
    step("stall_rs", 1'b0, 1'b1, 4'b1000, 14'h0000, 14'h0000, 14'h0000);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_fetch_pc_unit
`default_nettype wire
